// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      VERIFY = 2'd2
   } cfg_state_t;

   // Host words needed to cover one full pass of the chain.
   function automatic int numWords(input int chainLen, input int wordW);
      return (chainLen + wordW - 1) / wordW;
   endfunction

   // Bits needed for a counter that must hold values 0..maxVal.
   function automatic int cntW(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word buffer that turns host words into a bit stream, LSB first.
// Bits of the last word of a pass beyond the chain length are dropped by
// loading a shorter bit budget for that word.
module cfg_word_serializer
   import cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 32,
   parameter int WORD_W    = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              active,        // session in progress
   input  logic              passRollover,  // last bit of a non-final pass shifts now
   input  logic              take,          // current bitOut is consumed this cycle
   input  logic [WORD_W-1:0] wordIn,
   input  logic              wordValid,
   output logic              wordReady,
   output logic              bitOut,
   output logic              bitValid
);

   localparam int NW        = numWords(CHAIN_LEN, WORD_W);
   localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
   localparam int BW        = cntW(WORD_W);
   localparam int WW        = cntW(NW);

   logic [WORD_W-1:0] shiftReg;
   logic [BW-1:0]     bitsLeft;
   logic              full;
   logic [WW-1:0]     wordCnt;
   logic [WW-1:0]     wordCntEff;
   logic              lastShift;
   logic              load;

   // The word count restarts on the very edge that closes a pass, so the
   // first word of the next pass can be taken without a bubble.
   assign lastShift  = take & full & (bitsLeft == BW'(1));
   assign wordCntEff = passRollover ? '0 : wordCnt;
   assign wordReady  = active & (~full | lastShift) & (wordCntEff < WW'(NW));
   assign load       = wordValid & wordReady;
   assign bitValid   = full;
   assign bitOut     = full & shiftReg[0];

   // Buffer load / shift-out and per-pass word accounting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shiftReg <= '0;
         bitsLeft <= '0;
         full     <= 1'b0;
         wordCnt  <= '0;
      end else if (!active) begin
         bitsLeft <= '0;
         full     <= 1'b0;
         wordCnt  <= '0;
      end else if (load) begin
         shiftReg <= wordIn;
         full     <= 1'b1;
         bitsLeft <= (wordCntEff == WW'(NW - 1)) ? BW'(LAST_BITS) : BW'(WORD_W);
         wordCnt  <= wordCntEff + WW'(1);
      end else begin
         if (passRollover)
            wordCnt <= '0;
         if (take & full) begin
            shiftReg <= shiftReg >> 1;
            bitsLeft <= bitsLeft - BW'(1);
            if (lastShift)
               full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/config_loader.sv
// Head-of-chain driver for the configuration daisy chain: load pass, optional
// verify pass comparing the chain tail against the resent stream.
module config_loader
   import cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 32,
   parameter int WORD_W    = 32
)
(
   input  logic              Config_Clock,
   input  logic              Config_Reset,
   input  logic              start,
   input  logic              verify,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              cfg_data,
   output logic              cfg_en,
   input  logic              cfg_tail,
   output logic              busy,
   output logic              done,
   output logic              mismatch
);

   localparam int CW = cntW(CHAIN_LEN);

   cfg_state_t    state, stateNext;
   logic          verifyQ;
   logic [CW-1:0] bitCnt;
   logic          bitOut, bitValid;
   logic          passEnd, lastPass, passRollover, sessionStart;

   assign busy         = (state != IDLE);
   assign cfg_en       = busy & bitValid;
   assign cfg_data     = cfg_en & bitOut;
   assign passEnd      = cfg_en & (bitCnt == CW'(CHAIN_LEN - 1));
   assign lastPass     = (state == VERIFY) | ~verifyQ;
   assign passRollover = passEnd & ~lastPass;
   assign sessionStart = (state == IDLE) & start;

   cfg_word_serializer #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W)
   ) u_ser (
      .clk          (Config_Clock),
      .rst          (Config_Reset),
      .active       (busy),
      .passRollover (passRollover),
      .take         (cfg_en),
      .wordIn       (word_in),
      .wordValid    (word_valid),
      .wordReady    (word_ready),
      .bitOut       (bitOut),
      .bitValid     (bitValid)
   );

   // State register.
   always_ff @(posedge Config_Clock or posedge Config_Reset) begin
      if (Config_Reset) state <= IDLE;
      else              state <= stateNext;
   end

   // Next-state: passes advance only on the edge that shifts their last bit.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start)   stateNext = LOAD;
         LOAD:    if (passEnd) stateNext = verifyQ ? VERIFY : IDLE;
         VERIFY:  if (passEnd) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Pass bit counter, verify latch, done pulse and sticky mismatch.
   always_ff @(posedge Config_Clock or posedge Config_Reset) begin
      if (Config_Reset) begin
         verifyQ  <= 1'b0;
         bitCnt   <= '0;
         done     <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         done <= passEnd & lastPass;
         if (sessionStart) begin
            verifyQ  <= verify;
            bitCnt   <= '0;
            mismatch <= 1'b0;
         end else if (passEnd) begin
            bitCnt <= '0;
         end else if (cfg_en) begin
            bitCnt <= bitCnt + CW'(1);
         end
         // Tail is compared pre-edge against the bit being shifted in.
         if ((state == VERIFY) && cfg_en && (cfg_tail != cfg_data))
            mismatch <= 1'b1;
      end
   end

endmodule

// File: doc/config_loader.md
# config_loader

Serial configuration-chain driver: the transmitting end of the CGRA `ConfigIn`/`ConfigOut` daisy chain that every configurable cell shifts through. It accepts a bitstream from a host as 32-bit words over a valid/ready handshake, serializes it LSB-first onto the chain head, and gates chain shifting with an enable. An optional verify pass reshifts the same stream and compares the chain tail against it, bit for bit. It sits between the host/bitstream memory and the top-level fabric configuration port.

## Interface
- `CHAIN_LEN`, 32: total configuration bits in the chain (≥1).
- `WORD_W`, 32: host word width.
- `Config_Clock` in 1: configuration clock.
- `Config_Reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a session; sampled only in IDLE.
- `verify` in 1: sampled with `start`; 1 = load pass followed by a verify pass.
- `word_in` in WORD_W: bitstream word, consumed LSB-first.
- `word_valid` in 1: `word_in` valid.
- `word_ready` out 1: loader accepts `word_in` this cycle.
- `cfg_data` out 1: drives the chain-head `ConfigIn`.
- `cfg_en` out 1: shift enable for the chain clock gate. The chain shifts on a `Config_Clock` edge only when this is 1.
- `cfg_tail` in 1: chain-tail `ConfigOut`.
- `busy` out 1: session in progress.
- `done` out 1: one-cycle pulse at session end.
- `mismatch` out 1: sticky verify failure; cleared by `start`.

## Operation
- States: IDLE, LOAD, VERIFY.
  - IDLE→LOAD on `start`. This latches `verify`, clears `mismatch`, and zeroes the bit counter.
  - LOAD→VERIFY after CHAIN_LEN shifts if verify was latched; otherwise LOAD→IDLE.
  - VERIFY→IDLE after CHAIN_LEN shifts.
- Each pass needs NW = ceil(CHAIN_LEN/WORD_W) words. In the final word, bits above index (CHAIN_LEN−1) mod WORD_W are discarded.
- Word buffer: one word shift register plus a bit-in-word counter and a full flag.
  - `word_ready` = busy & (buffer empty | last needed bit of the buffered word shifts this cycle) & words accepted this pass < NW.
  - Transfer occurs on `word_valid & word_ready`.
- Shift cycle: `cfg_en` = busy & buffer full; `cfg_data` = buffer bit 0.
  - An empty buffer stalls: `cfg_en`=0 and `cfg_data`=0.
- Verify: on every VERIFY shift cycle, compare `cfg_tail` with `cfg_data`. Any inequality sets `mismatch`.
  - Rationale: the tail bit before shift k of pass 2 equals bit k of pass 1.
  - The host resends the identical stream for pass 2.
- `start` while busy is ignored. `word_valid` in IDLE is ignored (`word_ready`=0).
- Bit counter width is clog2(CHAIN_LEN+1). The counter resets to 0 at each pass boundary.

## Timing
- Reset values: IDLE, `word_ready`=0, `cfg_en`=0, `cfg_data`=0, `busy`=0, `done`=0, `mismatch`=0. The buffer is empty.
- `busy` rises the cycle after `start` and falls the same cycle `done` pulses.
- `done` pulses the cycle after the final shift edge of the last pass.
- Latency: a word accepted at edge t has its bit 0 on `cfg_data` with `cfg_en`=1 in cycle t+1.
- Back-to-back words: the next word can be accepted on the edge that shifts the last bit of the current word. With `word_valid` held high this gives zero bubbles, so exactly CHAIN_LEN `cfg_en` cycles occur per pass.
- Pass boundary: no bubble is required. The first bit of pass 2 may shift the cycle after the last bit of pass 1.
- `cfg_tail` is sampled in the same cycle as `cfg_en` (pre-edge value). It is not registered.
- Reset mid-session: everything returns to reset values immediately. The partially loaded chain is left as-is; `cfg_en`=0 guarantees no further shifts.

## Structure
- Shared package `cfg_pkg`:
  - state enum `cfg_state_t` {IDLE, LOAD, VERIFY};
  - a function computing NW;
  - a counter-width localparam helper.
- One natural sub-module, `cfg_word_serializer`. It owns the word buffer, bit-in-word counter, full flag and discard of final-word excess bits, and exposes `bit_out`, `bit_valid`, `take`, plus the word handshake.
- The top holds the FSM, pass/bit counter, verify comparator and `done`/`mismatch`.

## Test plan
The bench models the chain as a CHAIN_LEN-bit shift register clocked by `cfg_en`.
- CHAIN_LEN=32, no verify, one word 0xDEADBEEF with `word_valid` held:
  - 32 consecutive `cfg_en` cycles, `cfg_data` sequence 1,1,1,1,0,1,1,1…;
  - model contents equal 0xDEADBEEF, with bit 0 at the tail;
  - `done` pulses once.
- CHAIN_LEN=40, two words 0x12345678 and 0x000000AB:
  - exactly 40 shifts;
  - the upper 24 bits of word 2 are discarded;
  - `word_ready`=0 after the 2nd acceptance.
- CHAIN_LEN=40, verify=1, same stream sent twice: 80 shifts, `mismatch`=0, `done` after the 80th shift.
- Same as the previous case but bit 3 of word 1 is flipped in pass 2: `mismatch` rises the cycle after the 4th VERIFY shift and stays 1 until the next `start`.
- `word_valid` toggled 1-0-0-1 during the load: `cfg_en` is low exactly while the buffer is empty, and the final model contents are unchanged.
- `Config_Reset` asserted after 10 shifts:
  - all outputs go to reset values immediately and the model stops shifting;
  - a subsequent `start` followed by a full stream loads correctly;
  - `start` pulsed while busy has no effect.
